// File: rtl/conv_result_reader_if.sv
// Frame-in / byte-stream-out bundle between the 3x3 array, the result reader and its consumer.
// The reader itself connects through the slave modport.
interface conv_result_reader_if;
  logic       done_3_3;
  logic [7:0] result11;
  logic [7:0] result12;
  logic [7:0] result21;
  logic [7:0] result22;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_index;
  logic       out_last;

  modport master (
    output done_3_3, result11, result12, result21, result22, out_ready,
    input  out_data, out_valid, out_index, out_last
  );

  modport slave (
    input  done_3_3, result11, result12, result21, result22, out_ready,
    output out_data, out_valid, out_index, out_last
  );
endinterface

// File: rtl/conv_result_reader.sv
// Buffers 2x2 convolution result frames in a small circular queue and streams
// them out byte by byte (r11, r12, r21, r22) over a valid/ready handshake.
module conv_result_reader #(
  parameter int unsigned DEPTH_FRAMES = 2,
  parameter bit          RELU_EN      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_result_reader_if.slave  bus,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [2:0] FULL      = 3'(DEPTH_FRAMES);
  localparam logic [1:0] LAST_SLOT = 2'(DEPTH_FRAMES - 1);

  logic [7:0] mem_q [4][4];

  logic [0:0] state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] idx_q, idx_d;
  logic       ov_q, ov_d;

  logic       hs;
  logic       pop;
  logic       push;
  logic       drop;
  logic [7:0] head_byte;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    hs   = (state_q == STREAM) && bus.out_ready;
    pop  = hs && (idx_q == 2'd3);
    // A frame arriving on the final-byte handshake reuses the slot being freed.
    push = bus.done_3_3 && ((count_q != FULL) || pop);
    drop = bus.done_3_3 && !push;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    idx_d    = hs   ? idx_q + 2'd1       : idx_q;
    state_d  = (count_d != 3'd0) ? STREAM : IDLE;

    ov_d = ov_q;
    if (drop) begin
      ov_d = 1'b1;
    end else if (clr_overrun) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      ov_q     <= ov_d;
    end
  end

  // Payload storage needs no reset: it is only read while a written frame is held.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q][0] <= bus.result11;
      mem_q[wr_ptr_q][1] <= bus.result12;
      mem_q[wr_ptr_q][2] <= bus.result21;
      mem_q[wr_ptr_q][3] <= bus.result22;
    end
  end

  always_comb begin
    head_byte     = mem_q[rd_ptr_q][idx_q];
    bus.out_valid = (state_q == STREAM);
    bus.out_index = idx_q;
    bus.out_last  = (state_q == STREAM) && (idx_q == 2'd3);
    bus.out_data  = '0;
    if (state_q == STREAM) begin
      bus.out_data = (RELU_EN && head_byte[7]) ? 8'd0 : head_byte;
    end
  end

  assign busy    = (count_q != 3'd0);
  assign overrun = ov_q;

endmodule
